// File: rtl/ctrl_useq.sv
// ctrl_useq: microcoded control sequencer.
// An accepted opcode indexes a dispatch table to find a microcode start
// address. Words are then emitted from the microcode store, one per
// ctrl_valid/ctrl_ready handshake, until a word flagged last. A watchdog
// limits each opcode to MAX_STEPS words. Both tables are loaded through
// the cfg_* port and return to a one-zero-word-per-opcode default on reset.
module ctrl_useq #(
    parameter int OP_W      = 7,
    parameter int CW_W      = 26,
    parameter int UC_DEPTH  = 32,
    parameter int MAX_STEPS = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          op_valid,
    output logic                          op_ready,
    input  logic [OP_W-1:0]               op_code,
    output logic                          ctrl_valid,
    input  logic                          ctrl_ready,
    output logic [CW_W-1:0]               ctrl_word,
    output logic                          ctrl_last,
    output logic [$clog2(MAX_STEPS):0]    ctrl_step,
    output logic [OP_W-1:0]               ctrl_op,
    output logic                          seq_err,
    input  logic                          cfg_we,
    input  logic                          cfg_sel,
    input  logic [((OP_W > $clog2(UC_DEPTH)) ? OP_W : $clog2(UC_DEPTH))-1:0] cfg_addr,
    input  logic [CW_W+$clog2(UC_DEPTH):0] cfg_wdata,
    output logic                          cfg_err
);

    localparam int UC_AW  = $clog2(UC_DEPTH);
    localparam int ST_W   = $clog2(MAX_STEPS) + 1;
    localparam int WD_W   = CW_W + 1 + UC_AW;
    localparam int DISP_N = 2 ** OP_W;

    // Microcode entry layout: {next, last, word}. Reset entry = {0, 1, 0}.
    localparam logic [WD_W-1:0] UC_RST = {{UC_AW{1'b0}}, 1'b1, {CW_W{1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_reg;
    logic [UC_AW-1:0]    pc_reg;
    logic [ST_W-1:0]     step_reg;
    logic [CW_W-1:0]     word_reg;
    logic                last_reg;
    logic [OP_W-1:0]     op_reg;
    logic                valid_reg;
    logic                seq_err_reg;
    logic                cfg_err_reg;

    // Tables are flop arrays: they must reinitialise on the async reset.
    logic [UC_AW-1:0]    disp_mem [DISP_N];
    logic [WD_W-1:0]     uc_mem   [UC_DEPTH];

    // Field views of every microcode entry.
    logic [CW_W-1:0]     uc_word [UC_DEPTH];
    logic                uc_last [UC_DEPTH];
    logic [UC_AW-1:0]    uc_next [UC_DEPTH];

    generate
        for (genvar gi = 0; gi < UC_DEPTH; gi++) begin : g_uc_fields
            assign uc_word[gi] = uc_mem[gi][CW_W-1:0];
            assign uc_last[gi] = uc_mem[gi][CW_W];
            assign uc_next[gi] = uc_mem[gi][CW_W+1 +: UC_AW];
        end
    endgenerate

    logic                cfg_write_ok;
    logic                accept;
    logic [UC_AW-1:0]    start_addr;
    logic [UC_AW-1:0]    next_pc;
    logic                at_step_limit;

    // Config writes are only honoured between opcodes, so the tables never
    // change underneath a running sequence.
    assign cfg_write_ok  = cfg_we && (state_reg == IDLE);
    assign op_ready      = (state_reg == IDLE) && !cfg_we;
    assign accept        = op_valid && op_ready;
    assign start_addr    = disp_mem[op_code];
    assign next_pc       = uc_next[pc_reg];
    assign at_step_limit = (step_reg == ST_W'(MAX_STEPS - 1));

    assign ctrl_valid = valid_reg;
    assign ctrl_word  = word_reg;
    assign ctrl_last  = last_reg;
    assign ctrl_step  = step_reg;
    assign ctrl_op    = op_reg;
    assign seq_err    = seq_err_reg;
    assign cfg_err    = cfg_err_reg;

    // Dispatch table: reset to start address 0, written from cfg port (sel=0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DISP_N; i++) begin
                disp_mem[i] <= '0;
            end
        end else if (cfg_write_ok && !cfg_sel) begin
            disp_mem[cfg_addr[OP_W-1:0]] <= cfg_wdata[UC_AW-1:0];
        end
    end

    // Microcode store: reset to single-word zero entries, written when sel=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < UC_DEPTH; i++) begin
                uc_mem[i] <= UC_RST;
            end
        end else if (cfg_write_ok && cfg_sel) begin
            uc_mem[cfg_addr[UC_AW-1:0]] <= cfg_wdata;
        end
    end

    // Sequencer FSM with registered outputs; the word for the next step is
    // fetched at the handshake edge so consecutive words have no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            pc_reg      <= '0;
            step_reg    <= '0;
            word_reg    <= '0;
            last_reg    <= 1'b0;
            op_reg      <= '0;
            valid_reg   <= 1'b0;
            seq_err_reg <= 1'b0;
            cfg_err_reg <= 1'b0;
        end else begin
            seq_err_reg <= 1'b0;
            cfg_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        pc_reg    <= start_addr;
                        op_reg    <= op_code;
                        step_reg  <= '0;
                        word_reg  <= uc_word[start_addr];
                        last_reg  <= uc_last[start_addr];
                        valid_reg <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (cfg_we) begin
                        cfg_err_reg <= 1'b1;
                    end
                    if (ctrl_ready) begin
                        if (last_reg) begin
                            valid_reg <= 1'b0;
                            state_reg <= IDLE;
                        end else if (at_step_limit) begin
                            // Runaway microcode: abort the opcode.
                            seq_err_reg <= 1'b1;
                            valid_reg   <= 1'b0;
                            state_reg   <= IDLE;
                        end else begin
                            pc_reg   <= next_pc;
                            step_reg <= step_reg + ST_W'(1);
                            word_reg <= uc_word[next_pc];
                            last_reg <= uc_last[next_pc];
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_useq.sv
// Directed testbench for ctrl_useq with default parameters.
module tb_ctrl_useq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [6:0]  op_code;
    logic        ctrl_valid;
    logic        ctrl_ready;
    logic [25:0] ctrl_word;
    logic        ctrl_last;
    logic [3:0]  ctrl_step;
    logic [6:0]  ctrl_op;
    logic        seq_err;
    logic        cfg_we;
    logic        cfg_sel;
    logic [6:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ctrl_useq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .ctrl_valid (ctrl_valid),
        .ctrl_ready (ctrl_ready),
        .ctrl_word  (ctrl_word),
        .ctrl_last  (ctrl_last),
        .ctrl_step  (ctrl_step),
        .ctrl_op    (ctrl_op),
        .seq_err    (seq_err),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_err    (cfg_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic sel, input logic [6:0] addr, input logic [31:0] data);
        cfg_sel   = sel;
        cfg_addr  = addr;
        cfg_wdata = data;
        cfg_we    = 1'b1;
        tick();
        cfg_we    = 1'b0;
        $display("cfg write sel=%0b addr=%02h data=%08h", sel, addr, data);
    endtask

    task automatic issue(input logic [6:0] op);
        op_code  = op;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        $display("op %02h issued: valid=%0b word=%07h last=%0b step=%0d", op, ctrl_valid, ctrl_word, ctrl_last, ctrl_step);
    endtask

    task automatic test_reset();
        rst_n = 1'b1; op_valid = 1'b0; op_code = '0; ctrl_ready = 1'b0;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        #1 rst_n = 1'b0;
        #2;
        total++; if (op_ready !== 1'b1)   begin bad++; $display("FAIL rst_op_ready got=%0b exp=1", op_ready); end
        total++; if (ctrl_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", ctrl_valid); end
        total++; if (ctrl_word !== 26'h0) begin bad++; $display("FAIL rst_word got=%h exp=0", ctrl_word); end
        total++; if (ctrl_last !== 1'b0)  begin bad++; $display("FAIL rst_last got=%0b exp=0", ctrl_last); end
        total++; if (ctrl_step !== 4'd0)  begin bad++; $display("FAIL rst_step got=%0d exp=0", ctrl_step); end
        total++; if (ctrl_op !== 7'h0)    begin bad++; $display("FAIL rst_op got=%h exp=0", ctrl_op); end
        total++; if (seq_err !== 1'b0)    begin bad++; $display("FAIL rst_seq_err got=%0b exp=0", seq_err); end
        total++; if (cfg_err !== 1'b0)    begin bad++; $display("FAIL rst_cfg_err got=%0b exp=0", cfg_err); end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_default_op();
        ctrl_ready = 1'b1;
        issue(7'h15);
        total++; if (ctrl_valid !== 1'b1) begin bad++; $display("FAIL dflt_valid got=%0b exp=1", ctrl_valid); end
        total++; if (ctrl_word !== 26'h0) begin bad++; $display("FAIL dflt_word got=%h exp=0", ctrl_word); end
        total++; if (ctrl_last !== 1'b1)  begin bad++; $display("FAIL dflt_last got=%0b exp=1", ctrl_last); end
        total++; if (ctrl_step !== 4'd0)  begin bad++; $display("FAIL dflt_step got=%0d exp=0", ctrl_step); end
        total++; if (ctrl_op !== 7'h15)   begin bad++; $display("FAIL dflt_op got=%h exp=15", ctrl_op); end
        total++; if (op_ready !== 1'b0)   begin bad++; $display("FAIL dflt_busy got=%0b exp=0", op_ready); end
        tick();
        total++; if (ctrl_valid !== 1'b0) begin bad++; $display("FAIL dflt_done_valid got=%0b exp=0", ctrl_valid); end
        total++; if (op_ready !== 1'b1)   begin bad++; $display("FAIL dflt_done_ready got=%0b exp=1", op_ready); end
    endtask

    task automatic test_multi_word();
        cfg_write(1'b1, 7'd3, {5'd9, 1'b0, 26'h0000ABC});
        cfg_write(1'b1, 7'd9, {5'd0, 1'b1, 26'h3FFFFFF});
        cfg_write(1'b0, 7'h42, 32'd3);
        ctrl_ready = 1'b1;
        issue(7'h42);
        total++; if (ctrl_word !== 26'h0000ABC) begin bad++; $display("FAIL multi_w0 got=%h exp=0000abc", ctrl_word); end
        total++; if (ctrl_step !== 4'd0 || ctrl_last !== 1'b0 || ctrl_valid !== 1'b1)
            begin bad++; $display("FAIL multi_s0 got step=%0d last=%0b valid=%0b exp step=0 last=0 valid=1", ctrl_step, ctrl_last, ctrl_valid); end
        tick();
        total++; if (ctrl_word !== 26'h3FFFFFF) begin bad++; $display("FAIL multi_w1 got=%h exp=3ffffff", ctrl_word); end
        total++; if (ctrl_step !== 4'd1 || ctrl_last !== 1'b1 || ctrl_valid !== 1'b1)
            begin bad++; $display("FAIL multi_s1 got step=%0d last=%0b valid=%0b exp step=1 last=1 valid=1", ctrl_step, ctrl_last, ctrl_valid); end
        tick();
        total++; if (ctrl_valid !== 1'b0) begin bad++; $display("FAIL multi_end got=%0b exp=0", ctrl_valid); end
    endtask

    task automatic test_stall();
        ctrl_ready = 1'b0;
        issue(7'h42);
        for (int c = 0; c < 3; c++) begin
            total++; if (ctrl_word !== 26'h0000ABC || ctrl_step !== 4'd0 || ctrl_valid !== 1'b1)
                begin bad++; $display("FAIL stall_hold c=%0d got word=%h step=%0d valid=%0b exp word=0000abc step=0 valid=1", c, ctrl_word, ctrl_step, ctrl_valid); end
            if (c == 2) ctrl_ready = 1'b1;
            tick();
        end
        total++; if (ctrl_word !== 26'h3FFFFFF || ctrl_step !== 4'd1 || ctrl_last !== 1'b1)
            begin bad++; $display("FAIL stall_adv got word=%h step=%0d last=%0b exp word=3ffffff step=1 last=1", ctrl_word, ctrl_step, ctrl_last); end
        tick();
        total++; if (ctrl_valid !== 1'b0) begin bad++; $display("FAIL stall_end got=%0b exp=0", ctrl_valid); end
    endtask

    task automatic test_watchdog();
        cfg_write(1'b1, 7'd5, {5'd5, 1'b0, 26'h1});
        cfg_write(1'b0, 7'h01, 32'd5);
        ctrl_ready = 1'b1;
        issue(7'h01);
        for (int k = 0; k < 8; k++) begin
            total++; if (ctrl_valid !== 1'b1 || ctrl_word !== 26'h1 || ctrl_step !== 4'(k) || ctrl_last !== 1'b0 || seq_err !== 1'b0)
                begin bad++; $display("FAIL wd_word k=%0d got valid=%0b word=%h step=%0d last=%0b err=%0b exp valid=1 word=1 step=%0d last=0 err=0",
                                      k, ctrl_valid, ctrl_word, ctrl_step, ctrl_last, seq_err, k); end
            tick();
        end
        total++; if (seq_err !== 1'b1)    begin bad++; $display("FAIL wd_err got=%0b exp=1", seq_err); end
        total++; if (ctrl_valid !== 1'b0) begin bad++; $display("FAIL wd_stop got=%0b exp=0", ctrl_valid); end
        tick();
        total++; if (seq_err !== 1'b0)    begin bad++; $display("FAIL wd_pulse got=%0b exp=0", seq_err); end
        total++; if (op_ready !== 1'b1 || ctrl_valid !== 1'b0)
            begin bad++; $display("FAIL wd_idle got ready=%0b valid=%0b exp ready=1 valid=0", op_ready, ctrl_valid); end
    endtask

    task automatic test_cfg_in_run();
        ctrl_ready = 1'b0;
        issue(7'h42);
        cfg_sel = 1'b0; cfg_addr = 7'h42; cfg_wdata = 32'd5; cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL run_cfg_err got=%0b exp=1", cfg_err); end
        total++; if (ctrl_word !== 26'h0000ABC || ctrl_step !== 4'd0 || ctrl_valid !== 1'b1)
            begin bad++; $display("FAIL run_cfg_hold got word=%h step=%0d valid=%0b exp word=0000abc step=0 valid=1", ctrl_word, ctrl_step, ctrl_valid); end
        tick();
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL run_cfg_pulse got=%0b exp=0", cfg_err); end
        ctrl_ready = 1'b1;
        tick();
        total++; if (ctrl_step !== 4'd1 || ctrl_word !== 26'h3FFFFFF)
            begin bad++; $display("FAIL run_cfg_cont got step=%0d word=%h exp step=1 word=3ffffff", ctrl_step, ctrl_word); end
        tick();
        issue(7'h42);
        total++; if (ctrl_word !== 26'h0000ABC) begin bad++; $display("FAIL run_cfg_readback got=%h exp=0000abc", ctrl_word); end
        repeat (2) tick();
        total++; if (ctrl_valid !== 1'b0) begin bad++; $display("FAIL run_cfg_end got=%0b exp=0", ctrl_valid); end
    endtask

    task automatic test_cfg_vs_op();
        ctrl_ready = 1'b1;
        cfg_sel = 1'b0; cfg_addr = 7'h42; cfg_wdata = 32'd9; cfg_we = 1'b1;
        op_code = 7'h42; op_valid = 1'b1;
        #1;
        total++; if (op_ready !== 1'b0) begin bad++; $display("FAIL coll_ready got=%0b exp=0", op_ready); end
        tick();
        cfg_we = 1'b0;
        total++; if (ctrl_valid !== 1'b0 || cfg_err !== 1'b0)
            begin bad++; $display("FAIL coll_wait got valid=%0b cfg_err=%0b exp valid=0 cfg_err=0", ctrl_valid, cfg_err); end
        #1;
        total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL coll_ready2 got=%0b exp=1", op_ready); end
        tick();
        op_valid = 1'b0;
        $display("op 42 accepted after cfg write: word=%07h last=%0b", ctrl_word, ctrl_last);
        total++; if (ctrl_valid !== 1'b1 || ctrl_word !== 26'h3FFFFFF || ctrl_last !== 1'b1 || ctrl_op !== 7'h42)
            begin bad++; $display("FAIL coll_newent got valid=%0b word=%h last=%0b op=%h exp valid=1 word=3ffffff last=1 op=42", ctrl_valid, ctrl_word, ctrl_last, ctrl_op); end
        tick();
        total++; if (ctrl_valid !== 1'b0) begin bad++; $display("FAIL coll_end got=%0b exp=0", ctrl_valid); end
    endtask

    task automatic test_mid_reset();
        cfg_write(1'b0, 7'h42, 32'd3);
        ctrl_ready = 1'b1;
        issue(7'h42);
        tick();
        total++; if (ctrl_step !== 4'd1 || ctrl_valid !== 1'b1)
            begin bad++; $display("FAIL mrst_pre got step=%0d valid=%0b exp step=1 valid=1", ctrl_step, ctrl_valid); end
        rst_n = 1'b0;
        #1;
        total++; if (ctrl_valid !== 1'b0 || op_ready !== 1'b1 || ctrl_step !== 4'd0)
            begin bad++; $display("FAIL mrst_async got valid=%0b ready=%0b step=%0d exp valid=0 ready=1 step=0", ctrl_valid, op_ready, ctrl_step); end
        #1 rst_n = 1'b1;
        issue(7'h42);
        total++; if (ctrl_valid !== 1'b1 || ctrl_word !== 26'h0 || ctrl_last !== 1'b1 || ctrl_step !== 4'd0)
            begin bad++; $display("FAIL mrst_dflt42 got valid=%0b word=%h last=%0b step=%0d exp valid=1 word=0 last=1 step=0", ctrl_valid, ctrl_word, ctrl_last, ctrl_step); end
        tick();
        issue(7'h01);
        total++; if (ctrl_word !== 26'h0 || ctrl_last !== 1'b1 || ctrl_op !== 7'h01)
            begin bad++; $display("FAIL mrst_dflt01 got word=%h last=%0b op=%h exp word=0 last=1 op=01", ctrl_word, ctrl_last, ctrl_op); end
        tick();
        total++; if (ctrl_valid !== 1'b0) begin bad++; $display("FAIL mrst_end got=%0b exp=0", ctrl_valid); end
    endtask

    initial begin
        test_reset();
        test_default_op();
        test_multi_word();
        test_stall();
        test_watchdog();
        test_cfg_in_run();
        test_cfg_vs_op();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_useq.md
Name: ctrl_useq

Overview:
- Microcoded control sequencer; parametrised successor of the flat 7-input/26-output control decoder.
- Accepts an opcode over a valid/ready handshake and looks up a start address in a programmable dispatch table.
- Emits one or more control words from a programmable microcode store, one word per handshake, until a word marked last.
- Sits between instruction fetch/issue and datapath control; both tables are loaded through a config write port.

Parameters:
- OP_W, 7, opcode width; dispatch table has 2^OP_W entries.
- CW_W, 26, control word width.
- UC_DEPTH, 32, microcode entries (power of two); UC_AW = clog2(UC_DEPTH).
- MAX_STEPS, 8, watchdog limit on words emitted per opcode (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  opcode offered.
- op_ready  out  1  sequencer can accept an opcode.
- op_code  in  OP_W  opcode.
- ctrl_valid  out  1  control word valid.
- ctrl_ready  in  1  consumer accepts control word.
- ctrl_word  out  CW_W  current control word.
- ctrl_last  out  1  current word is final for this opcode.
- ctrl_step  out  clog2(MAX_STEPS)+1  index of current word within opcode, 0-based.
- ctrl_op  out  OP_W  opcode being sequenced.
- seq_err  out  1  one-cycle pulse: watchdog abort.
- cfg_we  in  1  config write strobe.
- cfg_sel  in  1  0 = dispatch table, 1 = microcode store.
- cfg_addr  in  max(OP_W,UC_AW)  table address; upper bits ignored for the narrower table.
- cfg_wdata  in  CW_W+1+UC_AW  microcode: {next[UC_AW], last, word[CW_W]}; dispatch: low UC_AW bits = start address.
- cfg_err  out  1  one-cycle pulse: config write rejected.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: op_ready=1, ctrl_valid=0, ctrl_word=0, ctrl_last=0, ctrl_step=0, ctrl_op=0, seq_err=0, cfg_err=0.
  - Tables: every dispatch entry=0; every microcode entry = {next=0, last=1, word=0}.
  - Resulting default: every opcode emits exactly one all-zero word.
- States: IDLE, RUN.
- op_ready = (state==IDLE) and !cfg_we. Accept occurs when op_valid && op_ready.
- IDLE:
  - On accept: pc <= disp[op_code], ctrl_op <= op_code, step <= 0, state <= RUN.
  - Next cycle: ctrl_valid=1, ctrl_word/ctrl_last taken from uc[pc]. Latency is one clock from accept to first valid word.
- RUN:
  - ctrl_valid=1. ctrl_word, ctrl_last, ctrl_step and ctrl_op are held stable while ctrl_ready=0.
  - On ctrl_ready with last=1: state <= IDLE, ctrl_valid <= 0 next cycle.
  - No op accepted in the same cycle. Back-to-back issue is therefore one idle cycle between opcodes.
  - On ctrl_ready with last=0: pc <= uc[pc].next, step <= step+1. The next word is presented the following cycle with no bubble.
- Watchdog: if ctrl_ready is taken on a non-last word with step == MAX_STEPS-1, the sequencer:
  - pulses seq_err for one cycle,
  - returns to IDLE, ctrl_valid=0,
  - emits no further words for that opcode.
- pc wraps modulo UC_DEPTH. A self-loop (next == own address, last=0) is legal and terminated by the watchdog.
- Config writes:
  - Accepted only when state==IDLE. A write takes effect at the clock edge; reads are visible the next cycle.
  - cfg_we while RUN: write dropped, cfg_err pulses one cycle, sequencing continues unaffected.
  - cfg_we in IDLE coincident with op_valid: the write wins. op_ready=0 that cycle, so the op waits.
- Mid-operation reset: rst_n low in RUN returns to IDLE immediately (async), ctrl_valid=0, and reinitialises both tables.
- seq_err and cfg_err are never held for more than one cycle per event.

Test Plan:
- Reset, then op_code=7'h15 with ctrl_ready=1 -> one cycle later ctrl_valid=1, ctrl_word=0, ctrl_last=1, ctrl_step=0, ctrl_op=7'h15; next cycle ctrl_valid=0, op_ready=1.
- Program uc[3]={next=9,last=0,word=26'h0000ABC}, uc[9]={next=0,last=1,word=26'h3FFFFFF}, disp[7'h42]=3; issue 7'h42 -> words 0x0000ABC (step 0) then 0x3FFFFFF (step 1, last) on consecutive cycles.
- Same program with ctrl_ready low for 3 cycles on step 0 -> ctrl_word stays 0x0000ABC and step stays 0 for all 3 cycles; step 1 appears the cycle after ctrl_ready rises.
- uc[5]={next=5,last=0,word=1}, disp[7'h01]=5, MAX_STEPS=8 -> exactly 8 words of value 1 with steps 0..7, seq_err pulse on the 8th handshake, then IDLE.
- cfg_we=1 during RUN -> cfg_err pulse, table unchanged (readback via re-issue); cfg_we and op_valid together in IDLE -> write applied, op accepted next cycle using the new entry.
- rst_n pulsed low during step 1 of a multi-word op -> ctrl_valid=0 immediately; after release any opcode yields a single zero word.
